fetch_ctrl: RTL and testbench
=============================

Name: fetch_ctrl

Overview:
- Sequences the fetch stage of the pipelined RV32I core. Owns the fetch PC (PCF) and issues requests to instruction memory using a req/ready handshake.
- Delivers fetched instructions into the F/D boundary (InstrD, PCD, ValidD). Honours hazard-unit stalls, and applies branch/jump redirects and flushes from Execute.
- Sits between the hazard unit, instruction memory and the decode stage. Replaces the free-running enable-only fetch register.

Parameters:
- DATA_WIDTH, 32, width of PC, address and instruction.
- RESET_PC, 32'h0000_0000, PCF value after reset.
- NOP_INSTR, 32'h0000_0013, instruction placed in InstrD on flush/bubble (addi x0,x0,0).

Ports:
- clk  in  1  core clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- StallF  in  1  hazard unit: hold fetch and decode boundary.
- FlushD  in  1  hazard unit: insert bubble into decode.
- PCSrcE  in  1  redirect request from Execute (taken branch/jump).
- PCTargetE  in  DATA_WIDTH  redirect target.
- imem_req  out  1  instruction-memory request valid.
- imem_addr  out  DATA_WIDTH  request address.
- imem_ready  in  1  memory returns imem_rdata this cycle; completes the request.
- imem_rdata  in  DATA_WIDTH  instruction data, valid when imem_ready.
- PCF  out  DATA_WIDTH  current fetch PC.
- InstrD  out  DATA_WIDTH  instruction to decode.
- PCD  out  DATA_WIDTH  PC of InstrD.
- ValidD  out  1  InstrD is a real instruction (0 = bubble).

Behaviour:
- Reset (async, rst_n=0):
  - state=BOOT, PCF=RESET_PC, imem_req=0, imem_addr=RESET_PC.
  - InstrD=NOP_INSTR, PCD=0, ValidD=0, hold buffer empty.
- States: BOOT, FETCH, HOLD, DRAIN.
- BOOT: one cycle after rst_n deasserts, unconditionally go to FETCH. imem_req=0.
- FETCH: imem_req=1, imem_addr=PCF.
  - While imem_ready=0: req and addr are held stable. Changing addr mid-request is forbidden.
  - On imem_ready=1 with StallF=0: InstrD<=imem_rdata, PCD<=PCF, ValidD<=1, PCF<=PCF+4. Stay in FETCH, so back-to-back issue yields 1 instr/cycle with zero-wait memory.
  - On imem_ready=1 with StallF=1: latch imem_rdata and PCF into the hold buffer, go to HOLD. Decode outputs and PCF unchanged.
- HOLD: imem_req=0.
  - When StallF=0: InstrD<=buffer, PCD<=buffer PC, ValidD<=1, PCF<=PCF+4, go to FETCH.
- DRAIN: imem_req=1, imem_addr=old address, held until imem_ready. The response is discarded. Then go to FETCH at the already-updated PCF.
- StallF while FETCH is waiting (imem_ready=0): no effect until the response arrives.
- Redirect (PCSrcE=1) has highest priority, above StallF and above normal capture, in any state except BOOT:
  - PCF<=PCTargetE with bits[1:0] forced to 0.
  - InstrD<=NOP_INSTR, ValidD<=0. Hold buffer invalidated.
  - Next state:
    - FETCH with imem_ready=0 (request outstanding) -> DRAIN.
    - FETCH with imem_ready=1 -> response discarded, FETCH.
    - HOLD -> FETCH.
    - DRAIN -> stay DRAIN with the newest target.
- FlushD=1 (without PCSrcE): InstrD<=NOP_INSTR, ValidD<=0 on the next edge. It overrides a delivery in the same cycle; the delivered instruction is lost and PCF still advances. It has no effect on PCF or the fetch state. FlushD together with StallF: the flush wins for the decode outputs.
- Arithmetic: PCF+4 wraps modulo 2^DATA_WIDTH (32'hFFFF_FFFC -> 32'h0000_0000).
- Reset mid-request: the outstanding request is abandoned. Memory must tolerate imem_req dropping during reset.

Test Plan:
1. Reset, RESET_PC=0, zero-wait memory (imem_ready=1 always), rdata=addr^32'hA5A5_0000 -> PCF 0,4,8,...; InstrD/PCD follow one cycle later; ValidD=1 from the 2nd cycle after reset release.
2. imem_ready low for 3 cycles at PCF=0x10 -> imem_addr stays 0x10, imem_req=1 throughout; on ready, InstrD=data, PCD=0x10, PCF=0x14.
3. StallF=1 coinciding with the response at PCF=0x20 for 2 cycles -> state HOLD, imem_req=0, InstrD unchanged; after release InstrD=buffered word, PCD=0x20, PCF=0x24.
4. PCSrcE=1, PCTargetE=0x103 while a request to 0x40 is outstanding -> DRAIN; 0x40 response discarded; next request addr=0x100; ValidD=0 until the 0x100 instr arrives.
5. FlushD=1 while StallF=1 -> InstrD=0x0000_0013, ValidD=0; PCF unchanged.
6. RESET_PC=32'hFFFF_FFF8, zero-wait memory -> PCF sequence FFFF_FFF8, FFFF_FFFC, 0000_0000; rst_n pulsed low mid-request -> outputs return to reset values immediately (async).

Source files
------------

// File: rtl/fetch_ctrl.sv
// Fetch-stage sequencer: owns PCF, issues req/ready instruction-memory requests
// and drives the F/D boundary (InstrD, PCD, ValidD) under stall, flush and redirect.
module fetch_ctrl #(
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = 32'h0000_0000,
  parameter logic [DATA_WIDTH-1:0] NOP_INSTR  = 32'h0000_0013
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  StallF,
  input  logic                  FlushD,
  input  logic                  PCSrcE,
  input  logic [DATA_WIDTH-1:0] PCTargetE,
  output logic                  imem_req,
  output logic [DATA_WIDTH-1:0] imem_addr,
  input  logic                  imem_ready,
  input  logic [DATA_WIDTH-1:0] imem_rdata,
  output logic [DATA_WIDTH-1:0] PCF,
  output logic [DATA_WIDTH-1:0] InstrD,
  output logic [DATA_WIDTH-1:0] PCD,
  output logic                  ValidD
);

  typedef enum logic [1:0] {BOOT, FETCH, HOLD, DRAIN} state_t;

  state_t                state_q, state_nxt;
  logic [DATA_WIDTH-1:0] pcf_q, pcf_nxt;
  logic [DATA_WIDTH-1:0] instr_q, instr_nxt;
  logic [DATA_WIDTH-1:0] pcd_q, pcd_nxt;
  logic                  valid_q, valid_nxt;
  logic [DATA_WIDTH-1:0] hold_instr_q, hold_instr_nxt;
  logic [DATA_WIDTH-1:0] hold_pc_q, hold_pc_nxt;
  logic [DATA_WIDTH-1:0] drain_addr_q, drain_addr_nxt;
  logic [DATA_WIDTH-1:0] redirect_pc;

  assign redirect_pc = {PCTargetE[DATA_WIDTH-1:2], 2'b00};

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= BOOT;
      pcf_q        <= RESET_PC;
      instr_q      <= NOP_INSTR;
      pcd_q        <= '0;
      valid_q      <= 1'b0;
      hold_instr_q <= '0;
      hold_pc_q    <= '0;
      drain_addr_q <= RESET_PC;
    end else begin
      state_q      <= state_nxt;
      pcf_q        <= pcf_nxt;
      instr_q      <= instr_nxt;
      pcd_q        <= pcd_nxt;
      valid_q      <= valid_nxt;
      hold_instr_q <= hold_instr_nxt;
      hold_pc_q    <= hold_pc_nxt;
      drain_addr_q <= drain_addr_nxt;
    end
  end

  // Next-state logic; a redirect outranks stalls and captures, a flush then
  // overrides whatever the decode boundary would otherwise receive.
  always_comb begin
    state_nxt      = state_q;
    pcf_nxt        = pcf_q;
    instr_nxt      = instr_q;
    pcd_nxt        = pcd_q;
    valid_nxt      = valid_q;
    hold_instr_nxt = hold_instr_q;
    hold_pc_nxt    = hold_pc_q;
    drain_addr_nxt = drain_addr_q;

    case (state_q)
      BOOT: state_nxt = FETCH;

      FETCH: begin
        if (PCSrcE) begin
          pcf_nxt   = redirect_pc;
          instr_nxt = NOP_INSTR;
          valid_nxt = 1'b0;
          if (!imem_ready) begin
            state_nxt      = DRAIN;
            drain_addr_nxt = pcf_q;
          end
        end else if (imem_ready) begin
          if (!StallF) begin
            instr_nxt = imem_rdata;
            pcd_nxt   = pcf_q;
            valid_nxt = 1'b1;
            pcf_nxt   = pcf_q + DATA_WIDTH'(4);
          end else begin
            hold_instr_nxt = imem_rdata;
            hold_pc_nxt    = pcf_q;
            state_nxt      = HOLD;
          end
        end
      end

      // Leaving HOLD is the only way to consume the buffer, so a redirect
      // invalidates it simply by returning to FETCH.
      HOLD: begin
        if (PCSrcE) begin
          pcf_nxt   = redirect_pc;
          instr_nxt = NOP_INSTR;
          valid_nxt = 1'b0;
          state_nxt = FETCH;
        end else if (!StallF) begin
          instr_nxt = hold_instr_q;
          pcd_nxt   = hold_pc_q;
          valid_nxt = 1'b1;
          pcf_nxt   = pcf_q + DATA_WIDTH'(4);
          state_nxt = FETCH;
        end
      end

      DRAIN: begin
        if (PCSrcE) begin
          pcf_nxt   = redirect_pc;
          instr_nxt = NOP_INSTR;
          valid_nxt = 1'b0;
        end else if (imem_ready) begin
          state_nxt = FETCH;
        end
      end

      default: state_nxt = BOOT;
    endcase

    if (FlushD) begin
      instr_nxt = NOP_INSTR;
      valid_nxt = 1'b0;
    end
  end

  assign imem_req  = (state_q == FETCH) || (state_q == DRAIN);
  assign imem_addr = (state_q == DRAIN) ? drain_addr_q : pcf_q;
  assign PCF       = pcf_q;
  assign InstrD    = instr_q;
  assign PCD       = pcd_q;
  assign ValidD    = valid_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: directed scenarios plus a randomized run
// compared against a transaction-level model of the fetch stage.
module tb_fetch_ctrl;

  localparam logic [31:0] NOP  = 32'h0000_0013;
  localparam logic [31:0] XORK = 32'hA5A5_0000;
  localparam logic [31:0] WRAP_PC = 32'hFFFF_FFF8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        StallF, FlushD, PCSrcE, imem_ready;
  logic [31:0] PCTargetE, imem_rdata;
  logic        imem_req, ValidD;
  logic [31:0] imem_addr, PCF, InstrD, PCD;
  logic        imem_req2, ValidD2;
  logic [31:0] imem_addr2, PCF2, InstrD2, PCD2;

  int checks = 0;
  int errors = 0;

  fetch_ctrl #(.DATA_WIDTH(32), .RESET_PC(32'h0), .NOP_INSTR(NOP)) dut (
    .clk(clk), .rst_n(rst_n), .StallF(StallF), .FlushD(FlushD), .PCSrcE(PCSrcE),
    .PCTargetE(PCTargetE), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata), .PCF(PCF), .InstrD(InstrD),
    .PCD(PCD), .ValidD(ValidD)
  );

  fetch_ctrl #(.DATA_WIDTH(32), .RESET_PC(WRAP_PC), .NOP_INSTR(NOP)) dut_wrap (
    .clk(clk), .rst_n(rst_n), .StallF(StallF), .FlushD(FlushD), .PCSrcE(PCSrcE),
    .PCTargetE(PCTargetE), .imem_req(imem_req2), .imem_addr(imem_addr2),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata), .PCF(PCF2), .InstrD(InstrD2),
    .PCD(PCD2), .ValidD(ValidD2)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] timeout");
  end

  // Transaction-level model: a queue of parked responses and a pending discard.
  bit          m_booted;
  bit          m_discard;
  logic [31:0] m_discard_addr, m_pc, m_instr, m_pcd;
  bit          m_valid;
  logic [63:0] m_held[$];

  task automatic model_reset(input logic [31:0] rpc);
    m_booted = 0; m_discard = 0; m_discard_addr = rpc; m_pc = rpc;
    m_instr = NOP; m_pcd = 0; m_valid = 0; m_held.delete();
  endtask

  function automatic logic exp_req();
    return m_booted && (m_held.size() == 0);
  endfunction

  function automatic logic [31:0] exp_addr();
    return m_discard ? m_discard_addr : m_pc;
  endfunction

  task automatic model_step();
    logic [63:0] e;
    if (!m_booted) m_booted = 1;
    else if (PCSrcE) begin
      if (m_held.size() != 0) m_held.delete();
      else if (!m_discard && !imem_ready) begin
        m_discard = 1; m_discard_addr = m_pc;
      end
      m_pc = {PCTargetE[31:2], 2'b00}; m_instr = NOP; m_valid = 0;
    end else if (m_held.size() != 0) begin
      if (!StallF) begin
        e = m_held.pop_front();
        m_instr = e[63:32]; m_pcd = e[31:0]; m_valid = 1; m_pc = m_pc + 4;
      end
    end else if (imem_ready) begin
      if (m_discard) m_discard = 0;
      else if (!StallF) begin
        m_instr = imem_rdata; m_pcd = m_pc; m_valid = 1; m_pc = m_pc + 4;
      end else m_held.push_back({imem_rdata, m_pc});
    end
    if (m_booted && FlushD) begin
      m_instr = NOP; m_valid = 0;
    end
  endtask

  function automatic logic [129:0] obs_vec();
    return {imem_req, imem_addr, PCF, InstrD, PCD, ValidD};
  endfunction

  function automatic logic [129:0] exp_vec();
    return {exp_req(), exp_addr(), m_pc, m_instr, m_pcd, m_valid};
  endfunction

  // Drive one cycle of inputs, advance the model at the edge, return at negedge.
  task automatic apply_stimulus(input logic stall, input logic flush, input logic pcsrc,
                                input logic [31:0] target, input logic ready,
                                input logic [31:0] rdata);
    StallF = stall; FlushD = flush; PCSrcE = pcsrc; PCTargetE = target;
    imem_ready = ready; imem_rdata = rdata;
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 0; StallF = 0; FlushD = 0; PCSrcE = 0; PCTargetE = 0;
    imem_ready = 0; imem_rdata = 0;
    model_reset(32'h0);
    @(negedge clk); @(negedge clk);
    checks++; if (PCF !== 32'h0) begin errors++; $display("FAIL reset_pcf got %h exp %h", PCF, 32'h0); end
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_req got %b exp 0", imem_req); end
    checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL reset_addr got %h exp 0", imem_addr); end
    checks++; if (InstrD !== NOP) begin errors++; $display("FAIL reset_instr got %h exp %h", InstrD, NOP); end
    checks++; if (PCD !== 32'h0) begin errors++; $display("FAIL reset_pcd got %h exp 0", PCD); end
    checks++; if (ValidD !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", ValidD); end
    checks++; if (PCF2 !== WRAP_PC) begin errors++; $display("FAIL reset_pcf2 got %h exp %h", PCF2, WRAP_PC); end
    checks++; if (imem_addr2 !== WRAP_PC) begin errors++; $display("FAIL reset_addr2 got %h exp %h", imem_addr2, WRAP_PC); end
    rst_n = 1;
  endtask

  task automatic test_zero_wait();
    for (int i = 0; i < 5; i++) begin
      apply_stimulus(0, 0, 0, 0, 1, exp_addr() ^ XORK);
      checks++;
      if (obs_vec() !== exp_vec()) begin errors++; $display("FAIL zero_wait cyc %0d got %h exp %h", i, obs_vec(), exp_vec()); end
      if (i == 0) begin
        checks++; if (ValidD !== 1'b0 || imem_req !== 1'b1) begin errors++; $display("FAIL boot_exit valid=%b req=%b exp valid=0 req=1", ValidD, imem_req); end
      end
      if (i == 1) begin
        checks++; if (ValidD !== 1'b1 || InstrD !== XORK || PCD !== 32'h0) begin errors++; $display("FAIL first_instr got %b/%h/%h exp 1/%h/0", ValidD, InstrD, PCD, XORK); end
      end
    end
    checks++; if (PCF !== 32'h10) begin errors++; $display("FAIL zero_wait_pcf got %h exp 10", PCF); end
  endtask

  task automatic test_wait_states();
    for (int i = 0; i < 3; i++) begin
      apply_stimulus(0, 0, 0, 0, 0, 32'hBAD0_0000);
      checks++;
      if (imem_addr !== 32'h10 || imem_req !== 1'b1) begin errors++; $display("FAIL wait_hold cyc %0d addr=%h req=%b exp 10/1", i, imem_addr, imem_req); end
    end
    apply_stimulus(0, 0, 0, 0, 1, 32'h10 ^ XORK);
    checks++;
    if (InstrD !== (32'h10 ^ XORK) || PCD !== 32'h10 || PCF !== 32'h14 || ValidD !== 1'b1) begin
      errors++; $display("FAIL wait_deliver got %h/%h/%h exp %h/10/14", InstrD, PCD, PCF, 32'h10 ^ XORK);
    end
  endtask

  task automatic test_stall_hold();
    for (int i = 0; i < 3; i++) apply_stimulus(0, 0, 0, 0, 1, exp_addr() ^ XORK);
    checks++; if (PCF !== 32'h20) begin errors++; $display("FAIL stall_pre_pcf got %h exp 20", PCF); end
    for (int i = 0; i < 2; i++) begin
      apply_stimulus(1, 0, 0, 0, 1, 32'h20 ^ XORK);
      checks++;
      if (imem_req !== 1'b0 || InstrD !== (32'h1C ^ XORK) || PCF !== 32'h20) begin
        errors++; $display("FAIL stall_hold cyc %0d req=%b instr=%h pcf=%h exp 0/%h/20", i, imem_req, InstrD, PCF, 32'h1C ^ XORK);
      end
    end
    apply_stimulus(0, 0, 0, 0, 1, 32'h1234_5678);
    checks++;
    if (InstrD !== (32'h20 ^ XORK) || PCD !== 32'h20 || PCF !== 32'h24 || ValidD !== 1'b1) begin
      errors++; $display("FAIL stall_release got %h/%h/%h exp %h/20/24", InstrD, PCD, PCF, 32'h20 ^ XORK);
    end
  endtask

  task automatic test_redirect_drain();
    for (int i = 0; i < 7; i++) apply_stimulus(0, 0, 0, 0, 1, exp_addr() ^ XORK);
    apply_stimulus(0, 0, 0, 0, 0, 32'h0);
    checks++; if (imem_addr !== 32'h40 || imem_req !== 1'b1) begin errors++; $display("FAIL redir_pre addr=%h req=%b exp 40/1", imem_addr, imem_req); end
    apply_stimulus(0, 0, 1, 32'h103, 0, 32'h0);
    checks++;
    if (PCF !== 32'h100 || imem_addr !== 32'h40 || imem_req !== 1'b1 || ValidD !== 1'b0 || InstrD !== NOP) begin
      errors++; $display("FAIL redir_drain pcf=%h addr=%h req=%b valid=%b exp 100/40/1/0", PCF, imem_addr, imem_req, ValidD);
    end
    apply_stimulus(0, 0, 0, 0, 1, 32'hDEAD_BEEF);
    checks++;
    if (imem_addr !== 32'h100 || ValidD !== 1'b0 || InstrD !== NOP || PCF !== 32'h100) begin
      errors++; $display("FAIL redir_discard addr=%h valid=%b instr=%h exp 100/0/%h", imem_addr, ValidD, InstrD, NOP);
    end
    apply_stimulus(0, 0, 0, 0, 1, 32'h100 ^ XORK);
    checks++;
    if (InstrD !== (32'h100 ^ XORK) || PCD !== 32'h100 || ValidD !== 1'b1 || PCF !== 32'h104) begin
      errors++; $display("FAIL redir_target got %h/%h/%b exp %h/100/1", InstrD, PCD, ValidD, 32'h100 ^ XORK);
    end
  endtask

  task automatic test_flush_stall();
    apply_stimulus(1, 1, 0, 0, 1, 32'h104 ^ XORK);
    checks++;
    if (InstrD !== NOP || ValidD !== 1'b0 || PCF !== 32'h104) begin
      errors++; $display("FAIL flush_stall instr=%h valid=%b pcf=%h exp %h/0/104", InstrD, ValidD, PCF, NOP);
    end
    apply_stimulus(0, 0, 0, 0, 1, 32'h0);
    checks++;
    if (obs_vec() !== exp_vec()) begin errors++; $display("FAIL flush_release got %h exp %h", obs_vec(), exp_vec()); end
  endtask

  task automatic test_random();
    logic st, fl, pc, rd;
    for (int i = 0; i < 500; i++) begin
      st = ($urandom_range(0, 3) == 0);
      fl = ($urandom_range(0, 9) == 0);
      pc = ($urandom_range(0, 19) == 0);
      rd = ($urandom_range(0, 4) < 3);
      apply_stimulus(st, fl, pc, $urandom, rd, $urandom);
      checks++;
      if (obs_vec() !== exp_vec()) begin errors++; $display("FAIL random cyc %0d got %h exp %h", i, obs_vec(), exp_vec()); end
    end
  endtask

  task automatic test_wrap_and_async_reset();
    logic [31:0] exp_pc2[3];
    exp_pc2[0] = 32'hFFFF_FFF8; exp_pc2[1] = 32'hFFFF_FFFC; exp_pc2[2] = 32'h0000_0000;
    rst_n = 0;
    model_reset(32'h0);
    @(negedge clk);
    rst_n = 1;
    for (int i = 0; i < 3; i++) begin
      apply_stimulus(0, 0, 0, 0, 1, 32'h0);
      checks++;
      if (PCF2 !== exp_pc2[i]) begin errors++; $display("FAIL wrap_pcf cyc %0d got %h exp %h", i, PCF2, exp_pc2[i]); end
    end
    apply_stimulus(0, 0, 0, 0, 0, 32'h0);
    checks++; if (imem_req2 !== 1'b1) begin errors++; $display("FAIL wrap_midreq req=%b exp 1", imem_req2); end
    #2 rst_n = 0;
    #1;
    checks++;
    if (PCF2 !== WRAP_PC || imem_req2 !== 1'b0 || imem_addr2 !== WRAP_PC || InstrD2 !== NOP || PCD2 !== 32'h0 || ValidD2 !== 1'b0) begin
      errors++; $display("FAIL async_reset2 pcf=%h req=%b addr=%h instr=%h valid=%b", PCF2, imem_req2, imem_addr2, InstrD2, ValidD2);
    end
    checks++;
    if (PCF !== 32'h0 || imem_req !== 1'b0 || ValidD !== 1'b0 || InstrD !== NOP) begin
      errors++; $display("FAIL async_reset1 pcf=%h req=%b valid=%b instr=%h", PCF, imem_req, ValidD, InstrD);
    end
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_wait_states();
    test_stall_hold();
    test_redirect_drain();
    test_flush_stall();
    test_random();
    test_wrap_and_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
